// File: rtl/br_update_queue_pkg.sv
// Shared types for the branch update queue: privilege domain and per-entry payload.
// Also holds the prediction-correctness rule used at retire.
package br_update_queue_pkg;

  typedef enum logic [1:0] {
    DOM_USER    = 2'd0,
    DOM_SUPER   = 2'd1,
    DOM_HYPER   = 2'd2,
    DOM_MACHINE = 2'd3
  } domain_t;

  typedef struct packed {
    logic [31:0] idx;
    logic        pred;
    logic [31:0] ptarg;
    domain_t     domain;
    logic        taken;
    logic [31:0] atarg;
  } upd_entry_t;

  // A not-taken branch is correct on direction alone; a taken one also needs the target.
  function automatic logic pred_correct(input upd_entry_t e);
    return (e.pred == e.taken) && (!e.taken || (e.ptarg == e.atarg));
  endfunction

endpackage

// File: rtl/br_update_ctr.sv
// Head/tail/occupancy tracking for a power-of-two circular queue, zero-latency full flag.
// Caller gates push with !full; flush and reset return everything to empty next cycle.
module br_update_ctr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W:0]   count,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + PTR_W'(1);
      if (push) tail <= tail + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/br_update_queue.sv
// In-flight branch tracker feeding predictor training; in-order retire, pulse 2 cycles after head resolve.
// Allocation stalls when full (ready from registered count only); resolves never stall.
module br_update_queue
  import br_update_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  input  logic [31:0]      alloc_idx_i,
  input  logic             alloc_pred_i,
  input  logic [31:0]      alloc_targ_i,
  input  domain_t          alloc_domain_i,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             resolve_valid_i,
  input  logic [TAG_W-1:0] resolve_tag_i,
  input  logic             resolve_taken_i,
  input  logic [31:0]      resolve_targ_i,
  output logic             upd_en_o,
  output logic [31:0]      upd_idx_o,
  output logic             upd_br_result_o,
  output logic             upd_correct_o,
  output logic [31:0]      upd_targ_o,
  output domain_t          upd_domain_o,
  output logic [TAG_W:0]   count_o,
  output logic             err_o
);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             full;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] resolved;
  upd_entry_t       mem [DEPTH];

  logic       alloc_fire;
  logic       resolve_ok;
  logic       retire;
  upd_entry_t alloc_entry;
  upd_entry_t head_entry;

  assign alloc_fire = alloc_valid_i && !full;
  assign resolve_ok = valid[resolve_tag_i] && !resolved[resolve_tag_i];
  assign retire     = valid[head] && resolved[head];
  assign head_entry = mem[head];

  always_comb begin
    alloc_entry        = '0;
    alloc_entry.idx    = alloc_idx_i;
    alloc_entry.pred   = alloc_pred_i;
    alloc_entry.ptarg  = alloc_targ_i;
    alloc_entry.domain = alloc_domain_i;
  end

  br_update_ctr #(
    .DEPTH (DEPTH),
    .PTR_W (TAG_W)
  ) u_ctr (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (alloc_fire),
    .pop   (retire),
    .head  (head),
    .tail  (tail),
    .count (count),
    .full  (full)
  );

  // Alloc never hits the retiring slot (needs not-full) and a resolve can never
  // hit the retiring slot legally (it is already resolved), so no write conflicts.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid    <= '0;
      resolved <= '0;
    end else begin
      if (alloc_fire) begin
        valid[tail]    <= 1'b1;
        resolved[tail] <= 1'b0;
      end
      if (resolve_valid_i && resolve_ok) begin
        resolved[resolve_tag_i] <= 1'b1;
      end
      if (retire) begin
        valid[head]    <= 1'b0;
        resolved[head] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (alloc_fire) begin
        mem[tail] <= alloc_entry;
      end
      if (resolve_valid_i && resolve_ok) begin
        mem[resolve_tag_i].taken <= resolve_taken_i;
        mem[resolve_tag_i].atarg <= resolve_targ_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (!flush_i && resolve_valid_i && !resolve_ok) begin
      err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upd_en_o        <= 1'b0;
      upd_idx_o       <= '0;
      upd_br_result_o <= 1'b0;
      upd_correct_o   <= 1'b0;
      upd_targ_o      <= '0;
      upd_domain_o    <= DOM_USER;
    end else if (flush_i) begin
      upd_en_o <= 1'b0;
    end else begin
      upd_en_o <= retire;
      if (retire) begin
        upd_idx_o       <= head_entry.idx;
        upd_br_result_o <= head_entry.taken;
        upd_correct_o   <= pred_correct(head_entry);
        upd_targ_o      <= head_entry.atarg;
        upd_domain_o    <= head_entry.domain;
      end
    end
  end

  assign alloc_ready_o = !full;
  assign alloc_tag_o   = tail;
  assign count_o       = count;

endmodule
